scratch_pad_memory: RTL and testbench

Single-port synchronous scratch-pad memory (SPM) for the instruction-fetch side of the CPU. It is word-addressed and sized by parameter. It accepts one read or one write per clock on the `if_spm_*` bus and returns read data with one-cycle latency. It sits beside the IF stage and serves as tightly-coupled local memory, with no bus arbitration.

---
 rtl/scratch_pad_memory.sv | 78 +++++++
 tb/tb_scratch_pad_memory.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/scratch_pad_memory.sv
// -----------------------------------------------------------------------------
// scratch_pad_memory
//
// Single-port, word-addressed scratch-pad memory that sits beside the IF stage
// as tightly-coupled local memory. One read or one write per clock, selected by
// an active-low address strobe. Read data is registered and appears one cycle
// after the address is sampled.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous active-high reset (clears rd data only)
//   if_spm_addr    word address, ADDR_W bits, full decode
//   if_spm_as_     address strobe, active-low (0 = access, 1 = idle)
//   if_spm_rw      access direction, 1 = read, 0 = write
//   if_spm_wr_data write data, DATA_W bits
//   if_spm_rd_data registered read data, DATA_W bits
//
// Configuration macro: SPM_WRITE_FIRST_EN
//   undefined (default): write cycles leave rd data unchanged (no-change mode),
//                        maps directly onto a single-port block RAM.
//   defined            : write cycles also drive wr data onto rd data
//                        (write-first / write-through).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module scratch_pad_memory #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_spm_addr,
  input  logic              if_spm_as_,
  input  logic              if_spm_rw,
  input  logic [DATA_W-1:0] if_spm_wr_data,
  output logic [DATA_W-1:0] if_spm_rd_data
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam int   DEPTH    = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic access;
  logic rd_en;
  logic wr_en;

  // The strobe is checked first so an undriven rw during idle cycles cannot
  // leak into the enables.
  always_comb begin
    access = (if_spm_as_ == ENABLE_);
    rd_en  = access && (if_spm_rw == READ);
    wr_en  = access && (if_spm_rw == WRITE);
  end

  // Storage has no reset so it infers as block RAM; contents survive reset.
  // An access coinciding with reset is dropped, hence the explicit rst gate.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[if_spm_addr] <= if_spm_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_spm_rd_data <= '0;
    end else if (rd_en) begin
      if_spm_rd_data <= mem[if_spm_addr];
`ifdef SPM_WRITE_FIRST_EN
    end else if (wr_en) begin
      if_spm_rd_data <= if_spm_wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_scratch_pad_memory.sv
`timescale 1ns/1ps

module tb_scratch_pad_memory;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              as_;
  logic              rw;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  typedef struct {
    logic [DATA_W-1:0] exp;
    string             name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  scratch_pad_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_spm_addr    (addr),
    .if_spm_as_     (as_),
    .if_spm_rw      (rw),
    .if_spm_wr_data (wr_data),
    .if_spm_rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [DATA_W-1:0] exp, input string name);
    vectors++;
    if (rd_data !== exp) begin
      miscompares++;
      $display("FAIL %s: rd_data=%h expected=%h", name, rd_data, exp);
    end
  endtask

  // Monitor: each driven cycle queues exactly one expectation, checked just
  // after the rising edge that consumes it.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.exp, e.name);
    end
  end

  task automatic drive(input logic a_s, input logic r_w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp,
                       input string name);
    exp_t e;
    @(negedge clk);
    as_     = a_s;
    rw      = r_w;
    addr    = a;
    wr_data = d;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [DATA_W-1:0] exp, input string name);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, '0, '0, exp, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] held;
    rst = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    #2;
    check(32'h0, "reset_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle(20, 32'h0, "reset_idle_hold");

    for (int i = 0; i < 16; i++)
`ifdef SPM_WRITE_FIRST_EN
      drive(1'b0, 1'b0, ADDR_W'(i), DATA_W'(255 - i), DATA_W'(255 - i), "burst_write");
`else
      drive(1'b0, 1'b0, ADDR_W'(i), DATA_W'(255 - i), 32'h0, "burst_write");
`endif
`ifdef SPM_WRITE_FIRST_EN
    held = 32'd240;
`else
    held = 32'd0;
`endif
    idle(20, held, "post_write_idle");

    for (int i = 0; i < 16; i++)
      drive(1'b0, 1'b1, ADDR_W'(i), '0, DATA_W'(255 - i), "burst_read");
    idle(5, 32'd240, "read_hold");

`ifdef SPM_WRITE_FIRST_EN
    drive(1'b0, 1'b0, 12'h3FF, 32'hDEADBEEF, 32'hDEADBEEF, "raw_write_cycle");
`else
    drive(1'b0, 1'b0, 12'h3FF, 32'hDEADBEEF, 32'd240, "raw_write_cycle");
`endif
    drive(1'b0, 1'b1, 12'h3FF, '0, 32'hDEADBEEF, "raw_read");

`ifdef SPM_WRITE_FIRST_EN
    drive(1'b0, 1'b0, 12'h000, 32'hA5A50000, 32'hA5A50000, "low_write");
    drive(1'b0, 1'b0, 12'hFFF, 32'h5A5AFFFF, 32'h5A5AFFFF, "high_write");
`else
    drive(1'b0, 1'b0, 12'h000, 32'hA5A50000, 32'hDEADBEEF, "low_write");
    drive(1'b0, 1'b0, 12'hFFF, 32'h5A5AFFFF, 32'hDEADBEEF, "high_write");
`endif
    drive(1'b0, 1'b1, 12'h000, '0, 32'hA5A50000, "low_read");
    drive(1'b0, 1'b1, 12'hFFF, '0, 32'h5A5AFFFF, "high_read");
    drive(1'b0, 1'b1, 12'h000, '0, 32'hA5A50000, "low_reread");

    // Reset coincides with a write edge: write dropped, output cleared.
    drive(1'b0, 1'b0, 12'd5, 32'h12345678, 32'h0, "reset_mid_write");
    rst = 1'b1;
    #1;
    check(32'h0, "reset_mid_async");
    drive(1'b1, 1'b1, '0, '0, 32'h0, "reset_release_idle");
    rst = 1'b0;
    drive(1'b0, 1'b1, 12'd5, '0, 32'h000000FA, "reset_no_partial_write");

    // Strobe gating: write-looking cycles with the strobe high change nothing.
    drive(1'b1, 1'b0, 12'd5, 32'hFFFFFFFF, 32'h000000FA, "gated_write_hold");
    drive(1'b1, 1'bx, 12'd6, 32'h0BADF00D, 32'h000000FA, "gated_rw_x_hold");
    drive(1'b0, 1'b1, 12'd6, '0, 32'h000000F9, "gated_read_6");
    drive(1'b0, 1'b1, 12'd5, '0, 32'h000000FA, "gated_read_5");
    idle(3, 32'h000000FA, "final_hold");

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
